// File: rtl/slider_moves.sv
// slider_moves: ray-scanning move generator for sliding pieces. Scans the enabled
// directions from a source square, then writes one successor board per recorded move.
module slider_moves #(
  parameter int BOARD_DIM = 8,
  parameter int MAX_MOVES = 27,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic [31:0]       master_writedata
);

  localparam int CW    = $clog2(BOARD_DIM) + 2;
  localparam int SQ    = BOARD_DIM * BOARD_DIM;
  localparam int IW    = $clog2(SQ);
  localparam int CNT_W = $clog2(MAX_MOVES + 1);

  localparam logic signed [CW-1:0] ONE  = CW'(1);
  localparam logic signed [CW-1:0] NEG  = '1;
  localparam logic signed [CW-1:0] MAXC = CW'(BOARD_DIM - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SRC, DIR_SEL, STEP, RD_DST, CLASSIFY,
    BRD_SEL, CP_RD, CP_WR, NEXT_SQ, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]    src_base, dst_base;
  logic signed [CW-1:0] src_x, src_y, cur_x, cur_y, nxt_x, nxt_y, dx, dy;
  logic [1:0]           mode;
  logic [7:0]           src_piece, dst_piece, cp_data, wr_piece, dir_mask;
  logic [3:0]           dir_idx;
  logic [2:0]           dir_cur;
  logic [IW-1:0]        moves [MAX_MOVES];
  logic [CNT_W-1:0]     count, brd_k;
  logic                 overflow;
  logic [IW-1:0]        sq_i;
  logic                 req_done;
  logic                 cfg_ok, start, rd_res, rd_data_ok, off_board;
  logic                 buf_full, dst_empty, dst_enemy, dir_en;
  logic                 unused_rdata;

  function automatic logic [IW-1:0] square(input logic signed [CW-1:0] x,
                                           input logic signed [CW-1:0] y);
    return IW'(y) * IW'(BOARD_DIM) + IW'(x);
  endfunction

  assign unused_rdata = ^master_readdata[31:8];
  assign cfg_ok     = (state == IDLE) || (state == DONE);
  assign start      = cfg_ok && slave_write && (slave_address == 4'd0);
  assign rd_res     = (state == DONE) && slave_read && (slave_address == 4'd0);
  // Data counts only once the request has been (or is being) accepted.
  assign rd_data_ok = master_readdatavalid && (req_done || !master_waitrequest);
  assign nxt_x      = cur_x + dx;
  assign nxt_y      = cur_y + dy;
  assign off_board  = nxt_x[CW-1] || nxt_y[CW-1] || (nxt_x > MAXC) || (nxt_y > MAXC);
  assign buf_full   = (count == CNT_W'(MAX_MOVES));
  assign dst_empty  = (dst_piece == 8'd0);
  assign dst_enemy  = !dst_empty && (dst_piece[7] != src_piece[7]);
  assign dir_en     = dir_mask[dir_idx[2:0]];

  always_comb begin
    case (mode)
      2'd0:    dir_mask = 8'h0F;
      2'd1:    dir_mask = 8'hF0;
      2'd2:    dir_mask = 8'hFF;
      default: dir_mask = 8'h00;
    endcase
  end

  // Direction order: N, E, S, W, NE, SE, SW, NW with north being +y.
  always_comb begin
    dx = '0;
    dy = '0;
    case (dir_cur)
      3'd0:    dy = ONE;
      3'd1:    dx = ONE;
      3'd2:    dy = NEG;
      3'd3:    dx = NEG;
      3'd4:    begin dx = ONE; dy = ONE; end
      3'd5:    begin dx = ONE; dy = NEG; end
      3'd6:    begin dx = NEG; dy = NEG; end
      default: begin dx = NEG; dy = ONE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_done <= 1'b0;
    end else begin
      state    <= state_next;
      req_done <= (state_next == state) &&
                  (req_done || (master_read && !master_waitrequest));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = RD_SRC;
      RD_SRC:   if (rd_data_ok) state_next = (master_readdata[7:0] == 8'd0) ? DONE : DIR_SEL;
      DIR_SEL:  if (dir_idx[3]) state_next = BRD_SEL;
                else if (dir_en) state_next = STEP;
      STEP:     state_next = off_board ? DIR_SEL : RD_DST;
      RD_DST:   if (rd_data_ok) state_next = CLASSIFY;
      CLASSIFY: if (dst_empty || dst_enemy)
                  state_next = buf_full ? BRD_SEL : (dst_empty ? STEP : DIR_SEL);
                else
                  state_next = DIR_SEL;
      BRD_SEL:  state_next = (brd_k < count) ? CP_RD : DONE;
      CP_RD:    if (rd_data_ok) state_next = CP_WR;
      CP_WR:    if (!master_waitrequest) state_next = NEXT_SQ;
      NEXT_SQ:  state_next = (sq_i == IW'(SQ - 1)) ? BRD_SEL : CP_RD;
      DONE:     if (start) state_next = RD_SRC;
                else if (rd_res) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_base  <= '0;
      dst_base  <= '0;
      src_x     <= '0;
      src_y     <= '0;
      mode      <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      src_piece <= '0;
      dst_piece <= '0;
      cp_data   <= '0;
      dir_idx   <= '0;
      dir_cur   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      brd_k     <= '0;
      sq_i      <= '0;
    end else begin
      if (cfg_ok && slave_write) begin
        case (slave_address)
          4'd0: begin
            count    <= '0;
            overflow <= 1'b0;
            dir_idx  <= '0;
            brd_k    <= '0;
          end
          4'd1:    src_base <= ADDR_W'(slave_writedata);
          4'd2:    dst_base <= ADDR_W'(slave_writedata);
          4'd3:    src_x    <= CW'(slave_writedata);
          4'd4:    src_y    <= CW'(slave_writedata);
          4'd5:    mode     <= slave_writedata[1:0];
          default: ;
        endcase
      end
      case (state)
        RD_SRC:   if (rd_data_ok) src_piece <= master_readdata[7:0];
        DIR_SEL:  if (!dir_idx[3]) begin
                    dir_idx <= dir_idx + 4'd1;
                    if (dir_en) begin
                      dir_cur <= dir_idx[2:0];
                      cur_x   <= src_x;
                      cur_y   <= src_y;
                    end
                  end
        STEP:     if (!off_board) begin
                    cur_x <= nxt_x;
                    cur_y <= nxt_y;
                  end
        RD_DST:   if (rd_data_ok) dst_piece <= master_readdata[7:0];
        CLASSIFY: if (dst_empty || dst_enemy) begin
                    if (buf_full) overflow <= 1'b1;
                    else          count    <= count + 1'b1;
                  end
        BRD_SEL:  sq_i <= '0;
        CP_RD:    if (rd_data_ok) cp_data <= master_readdata[7:0];
        NEXT_SQ:  if (sq_i == IW'(SQ - 1)) brd_k <= brd_k + 1'b1;
                  else                     sq_i  <= sq_i + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLASSIFY && (dst_empty || dst_enemy) && !buf_full)
      moves[count] <= square(cur_x, cur_y);
  end

  always_comb begin
    if (sq_i == moves[brd_k])              wr_piece = src_piece;
    else if (sq_i == square(src_x, src_y)) wr_piece = 8'd0;
    else                                   wr_piece = cp_data;
  end

  always_comb begin
    slave_waitrequest = !cfg_ok;
    slave_readdata    = '0;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = '0;
    master_writedata  = '0;
    if (state == IDLE || (state == DONE && slave_address == 4'd0))
      slave_readdata = {overflow, 23'd0, 8'(count)};
    case (state)
      RD_SRC: begin
        master_read    = !req_done;
        master_address = src_base + ADDR_W'(square(src_x, src_y));
      end
      RD_DST: begin
        master_read    = !req_done;
        master_address = src_base + ADDR_W'(square(cur_x, cur_y));
      end
      CP_RD: begin
        master_read    = !req_done;
        master_address = src_base + ADDR_W'(sq_i);
      end
      CP_WR: begin
        master_write     = 1'b1;
        master_address   = dst_base + ADDR_W'(brd_k) * ADDR_W'(SQ) + ADDR_W'(sq_i);
        master_writedata = {{24{wr_piece[7]}}, wr_piece};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slider_moves.sv
// Scoreboard bench for slider_moves: a ray-walking reference model predicts every
// board write, a monitor checks them as the DUT issues them on the SDRAM bus.
module tb_slider_moves;

  localparam int DIM = 8;
  localparam int SQ  = 64;
  localparam int SRC = 256;
  localparam int DST = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_addr = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        sel = 1'b0;
  logic        rand_on = 1'b0;
  logic        bus_wait = 1'b0, bus_rdvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        s_wait8, s_wait4, m_rd8, m_rd4, m_wr8, m_wr4;
  logic [31:0] s_rdata8, s_rdata4, m_addr8, m_addr4, m_wd8, m_wd4;
  logic        s_wait, m_rd, m_wr;
  logic [31:0] s_rdata, m_addr, m_wd;

  logic [31:0] mem [0:4095];
  int          brd [64];
  wr_t         exp_q [$];
  int          mv_q [$];
  int          dxs [8] = '{0, 1, 0, -1, 1, 1, -1, -1};
  int          dys [8] = '{1, 0, -1, 0, 1, -1, -1, 1};
  int          n_checks = 0, n_fail = 0;
  int          rd_left = -1, rd_delay;
  logic [31:0] rd_word;
  wr_t         mon_e;

  slider_moves dut8 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(s_wait8), .slave_address(s_addr),
    .slave_read(s_read & ~sel), .slave_write(s_write & ~sel),
    .slave_writedata(s_wdata), .slave_readdata(s_rdata8),
    .master_waitrequest(bus_wait), .master_address(m_addr8),
    .master_read(m_rd8), .master_write(m_wr8),
    .master_readdata(bus_rdata), .master_readdatavalid(bus_rdvalid),
    .master_writedata(m_wd8)
  );

  slider_moves #(.MAX_MOVES(4)) dut4 (
    .clk(clk), .rst(rst),
    .slave_waitrequest(s_wait4), .slave_address(s_addr),
    .slave_read(s_read & sel), .slave_write(s_write & sel),
    .slave_writedata(s_wdata), .slave_readdata(s_rdata4),
    .master_waitrequest(bus_wait), .master_address(m_addr4),
    .master_read(m_rd4), .master_write(m_wr4),
    .master_readdata(bus_rdata), .master_readdatavalid(bus_rdvalid),
    .master_writedata(m_wd4)
  );

  assign s_wait  = sel ? s_wait4  : s_wait8;
  assign s_rdata = sel ? s_rdata4 : s_rdata8;
  assign m_rd    = sel ? m_rd4    : m_rd8;
  assign m_wr    = sel ? m_wr4    : m_wr8;
  assign m_addr  = sel ? m_addr4  : m_addr8;
  assign m_wd    = sel ? m_wd4    : m_wd8;

  always #5 clk = ~clk;

  // Stall decision for the coming edge is made just after each rising edge.
  always @(posedge clk) begin
    #1;
    bus_wait = rand_on && ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    bus_rdvalid = 1'b0;
    if (rd_left == 0) begin
      bus_rdvalid = 1'b1;
      bus_rdata   = rd_word;
    end
    if (rd_left >= 0) rd_left--;
    if (m_rd && !bus_wait) begin
      rd_word  = mem[m_addr[11:0]];
      rd_delay = rand_on ? $urandom_range(0, 5) : 0;
      if (rd_delay == 0) begin
        bus_rdvalid = 1'b1;
        bus_rdata   = rd_word;
      end else begin
        rd_left = rd_delay - 1;
      end
    end
    if (m_wr && !bus_wait) mem[m_addr[11:0]] = m_wd;
  end

  always @(negedge clk) begin
    if (m_wr && !bus_wait) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL board write: got addr %0d data %0h, required no write", m_addr, m_wd);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_addr !== mon_e.addr || m_wd !== mon_e.data) begin
          n_fail++;
          $display("[TB] FAIL board write: got addr %0d data %0h, required addr %0d data %0h",
                   m_addr, m_wd, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cpuWrite(input logic [3:0] a, input logic [31:0] d);
    int g = 0;
    s_addr = a; s_wdata = d; s_write = 1'b1;
    #1;
    while (s_wait && g < 100000) begin @(negedge clk); g++; end
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic cpuRead(input logic [3:0] a, output logic [31:0] d);
    int g = 0;
    s_addr = a; s_read = 1'b1;
    #1;
    while (s_wait && g < 100000) begin @(negedge clk); #1; g++; end
    d = s_rdata;
    @(negedge clk);
    s_read = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int g = 0;
    while (s_wait && g < 40000) begin @(negedge clk); g++; end
    if (s_wait) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s completion: still busy after %0d cycles, required idle", name, g);
    end
  endtask

  task automatic clearBoard();
    for (int i = 0; i < SQ; i++) brd[i] = 0;
  endtask

  // Reference model: walk each ray square by square over the board array.
  task automatic buildExpected(input int sx, input int sy, input int mode, input int maxm,
                               output int cnt, output bit ovf);
    int piece, lo, hi, x, y, t;
    bit stop;
    mv_q.delete();
    ovf = 0; stop = 0;
    piece = brd[sy*DIM + sx];
    lo = (mode == 1) ? 4 : 0;
    hi = (mode == 0) ? 3 : ((mode == 3) ? -1 : 7);
    if (piece != 0) begin
      for (int d = lo; d <= hi && !stop; d++) begin
        x = sx; y = sy;
        while (1) begin
          x += dxs[d]; y += dys[d];
          if (x < 0 || x >= DIM || y < 0 || y >= DIM) break;
          t = brd[y*DIM + x];
          if (t != 0 && ((t > 0) == (piece > 0))) break;
          if (mv_q.size() == maxm) begin ovf = 1; stop = 1; break; end
          mv_q.push_back(y*DIM + x);
          if (t != 0) break;
        end
      end
    end
    cnt = mv_q.size();
    foreach (mv_q[k]) begin
      for (int i = 0; i < SQ; i++) begin
        wr_t w;
        w.addr = DST + k*SQ + i;
        w.data = (i == mv_q[k]) ? piece : ((i == sy*DIM + sx) ? 0 : brd[i]);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic loadAndConfigure(input int sx, input int sy, input int mode);
    for (int i = 0; i < SQ; i++) mem[SRC + i] = brd[i];
    cpuWrite(4'd1, SRC);
    cpuWrite(4'd2, DST);
    cpuWrite(4'd3, sx);
    cpuWrite(4'd4, sy);
    cpuWrite(4'd5, mode);
  endtask

  task automatic applyStimulus(input int sx, input int sy, input int mode, input int maxm,
                               input bit rnd, input string name);
    int cnt;
    bit ovf;
    logic [31:0] rd, exp_res;
    rand_on = rnd;
    loadAndConfigure(sx, sy, mode);
    buildExpected(sx, sy, mode, maxm, cnt, ovf);
    exp_res = {ovf, 23'd0, 8'(cnt)};
    cpuWrite(4'd0, 32'd0);
    waitIdle(name);
    cpuRead(4'd3, rd);
    checkOutput({name, " other addr"}, rd, 32'd0);
    cpuRead(4'd0, rd);
    checkOutput({name, " result"}, rd, exp_res);
    checkOutput({name, " boards left"}, exp_q.size(), 32'd0);
    cpuRead(4'd0, rd);
    checkOutput({name, " idle result"}, rd, exp_res);
    rand_on = 1'b0;
  endtask

  initial begin
    int g, p;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset waitrequest", s_wait, 32'd0);
    checkOutput("reset readdata", s_rdata, 32'd0);
    checkOutput("reset master_read", m_rd, 32'd0);
    checkOutput("reset master_write", m_wr, 32'd0);
    checkOutput("reset master_address", m_addr, 32'd0);
    checkOutput("reset master_writedata", m_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    clearBoard(); brd[0] = 5;
    applyStimulus(0, 0, 0, 27, 1'b0, "rook corner");
    checkOutput("rook board0 dest", mem[DST + 8], 32'd5);
    checkOutput("rook board0 src", mem[DST + 0], 32'd0);

    clearBoard(); brd[0] = 3; brd[9] = 1;
    applyStimulus(0, 0, 1, 27, 1'b0, "bishop blocked");

    clearBoard(); brd[27] = -9; brd[43] = 1;
    applyStimulus(3, 3, 2, 27, 1'b0, "queen capture");
    checkOutput("queen capture square", mem[DST + SQ + 43], 32'hFFFF_FFF7);
    checkOutput("queen capture src", mem[DST + SQ + 27], 32'd0);

    applyStimulus(3, 3, 2, 27, 1'b1, "queen delayed");

    clearBoard(); brd[0] = 5;
    applyStimulus(0, 0, 3, 27, 1'b0, "mode none");

    sel = 1'b1;
    @(negedge clk);
    clearBoard(); brd[0] = 5;
    applyStimulus(0, 0, 0, 4, 1'b0, "rook overflow");
    sel = 1'b0;
    @(negedge clk);

    clearBoard(); brd[0] = 5;
    loadAndConfigure(0, 0, 0);
    begin
      int cnt;
      bit ovf;
      buildExpected(0, 0, 0, 27, cnt, ovf);
    end
    cpuWrite(4'd0, 32'd0);
    g = 0;
    while (!m_wr && g < 5000) begin @(negedge clk); g++; end
    checkOutput("abort reached copy", m_wr, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort waitrequest", s_wait, 32'd0);
    checkOutput("abort master_write", m_wr, 32'd0);
    checkOutput("abort master_read", m_rd, 32'd0);
    checkOutput("abort readdata", s_rdata, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    applyStimulus(0, 0, 0, 27, 1'b0, "rook rerun");

    for (int r = 0; r < 3; r++) begin
      int sx, sy;
      clearBoard();
      for (int i = 0; i < SQ; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          p = $urandom_range(1, 9);
          brd[i] = ($urandom_range(0, 1) == 1) ? -p : p;
        end
      end
      sx = $urandom_range(0, 7);
      sy = $urandom_range(0, 7);
      p = $urandom_range(1, 9);
      brd[sy*DIM + sx] = ($urandom_range(0, 1) == 1) ? -p : p;
      applyStimulus(sx, sy, $urandom_range(0, 3), 27, r[0], $sformatf("random %0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
